// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: holds fetch off during boot,
// then round-robins fetch and loader onto one 1-cycle-latency memory port.
`timescale 1ns/1ps

module imem_arbiter #(
  parameter int unsigned DEPTH   = 128,
  parameter logic [31:0] NOP     = 32'h00000013,
  parameter bit          BOOT_EN = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          fetch_req,
  input  logic [31:0]   fetch_pc,
  output logic          fetch_ready,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          misalign_err,

  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_ready,
  output logic          ld_valid,
  output logic [31:0]   ld_rdata,

  input  logic          boot_done,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // state   | meaning
  // --------+---------------------------------------------------------
  // ST_BOOT | loader owns the port, fetch held off until boot_done
  // ST_RUN  | round-robin between fetch and loader, until next rst
  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t      RST_STATE = BOOT_EN ? ST_BOOT : ST_RUN;
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);

  state_t state_q, state_d;

  logic grant_fetch, grant_ld;

  logic last_ld_q,    last_ld_d;
  logic pend_fetch_q, pend_fetch_d;
  logic pend_ld_q,    pend_ld_d;
  logic use_mem_q,    use_mem_d;
  logic mis_q,        mis_d;

  logic fetch_oor, fetch_mis, ld_oor;
  logic unused_ld_lsb;

  assign fetch_oor     = fetch_pc[31:2] >= DEPTH_W;
  assign fetch_mis     = |fetch_pc[1:0];
  assign ld_oor        = ld_addr[31:2] >= DEPTH_W;
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT && boot_done) begin
      state_d = ST_RUN;
    end
  end

  // Grant is purely combinational; on a tie the side not served last wins.
  always_comb begin
    grant_fetch = 1'b0;
    grant_ld    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_BOOT: grant_ld = ld_req;
        ST_RUN: begin
          if (fetch_req && ld_req) begin
            grant_fetch = last_ld_q;
            grant_ld    = !last_ld_q;
          end else begin
            grant_fetch = fetch_req;
            grant_ld    = ld_req;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_ready = grant_fetch;
  assign ld_ready    = grant_ld;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_fetch) begin
      mem_en    = !fetch_oor && !fetch_mis;
      mem_addr  = fetch_pc[AW+1:2];
      mem_wdata = ld_wdata;
    end else if (grant_ld) begin
      mem_en    = !ld_oor;
      mem_we    = ld_we && !ld_oor;
      mem_addr  = ld_addr[AW+1:2];
      mem_wdata = ld_wdata;
    end
  end

  // Response tags are captured at acceptance so N+1 never looks at requester inputs.
  always_comb begin
    pend_fetch_d = grant_fetch;
    pend_ld_d    = grant_ld;
    use_mem_d    = (grant_fetch && !fetch_oor && !fetch_mis) ||
                   (grant_ld && !ld_we && !ld_oor);
    mis_d        = grant_fetch && fetch_mis;
    last_ld_d    = last_ld_q;
    if (grant_ld) begin
      last_ld_d = 1'b1;
    end else if (grant_fetch) begin
      last_ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ld_q    <= 1'b0;
      pend_fetch_q <= 1'b0;
      pend_ld_q    <= 1'b0;
      use_mem_q    <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      last_ld_q    <= last_ld_d;
      pend_fetch_q <= pend_fetch_d;
      pend_ld_q    <= pend_ld_d;
      use_mem_q    <= use_mem_d;
      mis_q        <= mis_d;
    end
  end

  assign fetch_valid  = pend_fetch_q;
  assign fetch_instr  = (pend_fetch_q && use_mem_q) ? mem_rdata : NOP;
  assign misalign_err = pend_fetch_q && mis_q;
  assign ld_valid     = pend_ld_q;
  assign ld_rdata     = (pend_ld_q && use_mem_q) ? mem_rdata : 32'h0;

endmodule
